// File: rtl/sudoku_pkg.sv
// Shared types, board constants and group-to-cell mapping for the 4x4 Sudoku controller.
package sudoku_pkg;

    localparam int unsigned GRID_N    = 4;
    localparam int unsigned CELL_W    = 4;
    localparam int unsigned MAX_DIGIT = 4;
    localparam int unsigned N_CELLS   = GRID_N * GRID_N;

    typedef enum logic [1:0] {
        S_LOAD,
        S_PLAY,
        S_CHECK,
        S_WIN
    } state_e;

    // Group g: 0-3 rows, 4-7 columns, 8-11 2x2 boxes (row-major). Member i: 0..3.
    function automatic logic [3:0] group_cell(input logic [3:0] g, input logic [1:0] i);
        logic [1:0] r;
        logic [1:0] c;
        if (g < 4'd4) begin
            r = g[1:0];
            c = i;
        end else if (g < 4'd8) begin
            r = i;
            c = g[1:0];
        end else begin
            // Box index is g[1:0]: its top bit picks the box row, low bit the box column.
            r = {g[1], i[1]};
            c = {g[0], i[0]};
        end
        return {r, c};
    endfunction

endpackage

// File: rtl/sudoku_puzzle_rom.sv
// Combinational puzzle store: four 4x4 puzzles, 0 marks an empty cell.
module sudoku_puzzle_rom
    import sudoku_pkg::*;
(
    input  logic [1:0]        sel,
    input  logic [3:0]        idx,
    output logic [CELL_W-1:0] val
);

    logic [N_CELLS*CELL_W-1:0] puzzle;

    // Cell k lives in nibble k, so row 0 sits in the low 16 bits.
    always_comb begin
        unique case (sel)
            2'd0:    puzzle = 64'h0230_3002_0140_4001;
            2'd1:    puzzle = 64'h0230_4001_0140_3002;
            2'd2:    puzzle = 64'h0410_1004_0320_2003;
            default: puzzle = 64'h0400_0003_2000_0010;
        endcase
    end

    assign val = puzzle[idx*CELL_W +: CELL_W];

endmodule

// File: rtl/sudoku_game_ctrl.sv
// Game-state controller: loads a puzzle, moves the cursor, edits cells and scans the board.
module sudoku_game_ctrl
    import sudoku_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      btn_up,
    input  logic                      btn_down,
    input  logic                      btn_left,
    input  logic                      btn_right,
    input  logic                      btn_enter,
    input  logic                      btn_clear,
    input  logic                      btn_new,
    input  logic [1:0]                puzzle_sel,
    output logic [N_CELLS*CELL_W-1:0] grid,
    output logic [N_CELLS-1:0]        fixed_mask,
    output logic [1:0]                cursor_row,
    output logic [1:0]                cursor_col,
    output logic                      error_flag,
    output logic                      win_flag,
    output logic                      busy
);

    state_e                    state_q, state_d;
    logic [N_CELLS*CELL_W-1:0] grid_q, grid_d;
    logic [N_CELLS-1:0]        fixed_q, fixed_d;
    logic [1:0]                row_q, row_d;
    logic [1:0]                col_q, col_d;
    logic [1:0]                sel_q, sel_d;
    logic [3:0]                idx_q, idx_d;   // load cell index or scan group index
    logic                      err_q, err_d;
    logic                      win_q, win_d;
    logic                      acc_q, acc_d;   // running duplicate flag of the current scan

    logic [CELL_W-1:0] rom_val;
    logic [3:0]        cur;
    logic [CELL_W-1:0] cur_val;
    logic [CELL_W-1:0] inc_val;
    logic [CELL_W-1:0] gv [4];
    logic              dup;
    logic              full;
    logic              scan_err;

    sudoku_puzzle_rom u_rom (
        .sel (sel_q),
        .idx (idx_q),
        .val (rom_val)
    );

    assign cur      = {row_q, col_q};
    assign cur_val  = grid_q[cur*CELL_W +: CELL_W];
    assign inc_val  = (cur_val >= CELL_W'(MAX_DIGIT)) ? '0 : cur_val + 1'b1;
    assign scan_err = acc_q | dup;

    // Duplicate test for the group under scan, plus board-full detection.
    always_comb begin
        dup  = 1'b0;
        full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            gv[i] = grid_q[group_cell(idx_q, 2'(i))*CELL_W +: CELL_W];
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = i + 1; j < 4; j++) begin
                if (gv[i] != '0 && gv[i] == gv[j]) begin
                    dup = 1'b1;
                end
            end
        end
        for (int k = 0; k < N_CELLS; k++) begin
            if (grid_q[k*CELL_W +: CELL_W] == '0) begin
                full = 1'b0;
            end
        end
    end

    // Next-state and datapath updates for the load / play / check / win FSM.
    always_comb begin
        state_d = state_q;
        grid_d  = grid_q;
        fixed_d = fixed_q;
        row_d   = row_q;
        col_d   = col_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        err_d   = err_q;
        win_d   = win_q;
        acc_d   = acc_q;

        unique case (state_q)
            S_LOAD: begin
                grid_d[idx_q*CELL_W +: CELL_W] = rom_val;
                fixed_d[idx_q]                 = (rom_val != '0);
                idx_d                          = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    row_d   = '0;
                    col_d   = '0;
                    err_d   = 1'b0;
                    win_d   = 1'b0;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (btn_new) begin
                    sel_d   = puzzle_sel;
                    err_d   = 1'b0;
                    win_d   = 1'b0;
                    idx_d   = '0;
                    state_d = S_LOAD;
                end else if (btn_clear || btn_enter) begin
                    // A press on a given cell is swallowed entirely; no move falls through.
                    if (!fixed_q[cur]) begin
                        grid_d[cur*CELL_W +: CELL_W] = btn_clear ? '0 : inc_val;
                        idx_d   = '0;
                        acc_d   = 1'b0;
                        state_d = S_CHECK;
                    end
                end else if (btn_up) begin
                    row_d = row_q - 2'd1;
                end else if (btn_down) begin
                    row_d = row_q + 2'd1;
                end else if (btn_left) begin
                    col_d = col_q - 2'd1;
                end else if (btn_right) begin
                    col_d = col_q + 2'd1;
                end
            end
            S_CHECK: begin
                if (btn_new) begin
                    sel_d   = puzzle_sel;
                    err_d   = 1'b0;
                    win_d   = 1'b0;
                    idx_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    acc_d = scan_err;
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd11) begin
                        err_d   = scan_err;
                        win_d   = !scan_err && full;
                        state_d = (!scan_err && full) ? S_WIN : S_PLAY;
                    end
                end
            end
            S_WIN: begin
                if (btn_new) begin
                    sel_d   = puzzle_sel;
                    err_d   = 1'b0;
                    win_d   = 1'b0;
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // State register with synchronous reset that restarts a load of puzzle_sel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
            grid_q  <= '0;
            fixed_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            sel_q   <= puzzle_sel;
            idx_q   <= '0;
            err_q   <= 1'b0;
            win_q   <= 1'b0;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grid_q  <= grid_d;
            fixed_q <= fixed_d;
            row_q   <= row_d;
            col_q   <= col_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            win_q   <= win_d;
            acc_q   <= acc_d;
        end
    end

    assign grid       = grid_q;
    assign fixed_mask = fixed_q;
    assign cursor_row = row_q;
    assign cursor_col = col_q;
    assign error_flag = err_q;
    assign win_flag   = win_q;
    assign busy       = (state_q == S_LOAD) || (state_q == S_CHECK);

endmodule

// File: tb/tb_sudoku_game_ctrl.sv
// Self-checking bench for sudoku_game_ctrl: vector table, corner sequences, random vs. model.
module tb_sudoku_game_ctrl;

    localparam logic [6:0] B_NEW = 7'b1000000;
    localparam logic [6:0] B_CLR = 7'b0100000;
    localparam logic [6:0] B_ENT = 7'b0010000;
    localparam logic [6:0] B_UP  = 7'b0001000;
    localparam logic [6:0] B_DN  = 7'b0000100;
    localparam logic [6:0] B_LF  = 7'b0000010;
    localparam logic [6:0] B_RT  = 7'b0000001;

    localparam logic [63:0] P0_HEX  = 64'h0230_3002_0140_4001;
    localparam logic [63:0] P1_HEX  = 64'h0230_4001_0140_3002;
    localparam logic [63:0] P2_HEX  = 64'h0410_1004_0320_2003;
    localparam logic [63:0] SOL_HEX = 64'h1234_3412_2143_4321;

    localparam int M_LOAD  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_CHECK = 2;
    localparam int M_WON   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_up, btn_down, btn_left, btn_right, btn_enter, btn_clear, btn_new;
    logic [1:0]  puzzle_sel;
    logic [63:0] grid;
    logic [15:0] fixed_mask;
    logic [1:0]  cursor_row, cursor_col;
    logic        error_flag, win_flag, busy;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state.
    int puz [4][16];
    int m_cell [16];
    bit m_fixed [16];
    int m_row, m_col, m_sel, m_mode, m_cnt;
    bit m_err, m_win;

    typedef struct {
        logic [6:0] btn;
        int         idle;
        int         row;
        int         col;
        bit         busy;
    } vec_t;

    vec_t vecs [12];

    sudoku_game_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_enter  (btn_enter),
        .btn_clear  (btn_clear),
        .btn_new    (btn_new),
        .puzzle_sel (puzzle_sel),
        .grid       (grid),
        .fixed_mask (fixed_mask),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .error_flag (error_flag),
        .win_flag   (win_flag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Sudoku rule: two equal nonzero cells sharing a row, column or 2x2 box.
    function automatic bit board_dup();
        for (int a = 0; a < 16; a++) begin
            for (int b = a + 1; b < 16; b++) begin
                if (m_cell[a] != 0 && m_cell[a] == m_cell[b] &&
                    (a / 4 == b / 4 || a % 4 == b % 4 ||
                     (a / 8 == b / 8 && (a % 4) / 2 == (b % 4) / 2))) begin
                    return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    function automatic bit board_full();
        for (int a = 0; a < 16; a++) begin
            if (m_cell[a] == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void start_load();
        m_sel  = int'(puzzle_sel);
        m_err  = 1'b0;
        m_win  = 1'b0;
        m_mode = M_LOAD;
        m_cnt  = 0;
    endfunction

    // One clock of the game rules, using the inputs held across the edge.
    function automatic void model_step();
        int k;
        if (rst) begin
            for (int a = 0; a < 16; a++) begin
                m_cell[a]  = 0;
                m_fixed[a] = 1'b0;
            end
            m_row = 0;
            m_col = 0;
            start_load();
            return;
        end
        k = m_row * 4 + m_col;
        case (m_mode)
            M_LOAD: begin
                m_cell[m_cnt]  = puz[m_sel][m_cnt];
                m_fixed[m_cnt] = (puz[m_sel][m_cnt] != 0);
                m_cnt++;
                if (m_cnt == 16) begin
                    m_row  = 0;
                    m_col  = 0;
                    m_err  = 1'b0;
                    m_win  = 1'b0;
                    m_mode = M_PLAY;
                end
            end
            M_PLAY: begin
                if (btn_new) start_load();
                else if (btn_clear || btn_enter) begin
                    if (!m_fixed[k]) begin
                        m_cell[k] = btn_clear ? 0 : (m_cell[k] + 1) % 5;
                        m_mode    = M_CHECK;
                        m_cnt     = 12;
                    end
                end
                else if (btn_up)    m_row = (m_row + 3) % 4;
                else if (btn_down)  m_row = (m_row + 1) % 4;
                else if (btn_left)  m_col = (m_col + 3) % 4;
                else if (btn_right) m_col = (m_col + 1) % 4;
            end
            M_CHECK: begin
                if (btn_new) start_load();
                else begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_err  = board_dup();
                        m_win  = !m_err && board_full();
                        m_mode = m_win ? M_WON : M_PLAY;
                    end
                end
            end
            default: begin
                if (btn_new) start_load();
            end
        endcase
    endfunction

    task automatic cmp_all();
        logic [63:0] eg;
        logic [15:0] ef;
        for (int a = 0; a < 16; a++) begin
            eg[a*4 +: 4] = 4'(m_cell[a]);
            ef[a]        = m_fixed[a];
        end
        chk("grid", grid, eg);
        chk("fixed_mask", 64'(fixed_mask), 64'(ef));
        chk("cursor_row", 64'(cursor_row), 64'(m_row));
        chk("cursor_col", 64'(cursor_col), 64'(m_col));
        chk("error_flag", 64'(error_flag), 64'(m_err));
        chk("win_flag", 64'(win_flag), 64'(m_win));
        chk("busy", 64'(busy), 64'(m_mode == M_LOAD || m_mode == M_CHECK));
    endtask

    task automatic step(input logic [6:0] b, input logic r, input logic [1:0] s);
        {btn_new, btn_clear, btn_enter, btn_up, btn_down, btn_left, btn_right} = b;
        rst        = r;
        puzzle_sel = s;
        @(posedge clk);
        model_step();
        #1;
        cmp_all();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && (m_mode == M_LOAD || m_mode == M_CHECK); i++) begin
            step(7'd0, 1'b0, 2'd0);
        end
    endtask

    task automatic goto_cell(input int r, input int c);
        for (int i = 0; i < 4 && m_row != r; i++) step(B_DN, 1'b0, 2'd0);
        for (int i = 0; i < 4 && m_col != c; i++) step(B_RT, 1'b0, 2'd0);
    endtask

    task automatic enter_n(input int n);
        for (int i = 0; i < n; i++) begin
            step(B_ENT, 1'b0, 2'd0);
            wait_idle();
        end
    endtask

    initial begin
        puz[0] = '{1,0,0,4, 0,4,1,0, 2,0,0,3, 0,3,2,0};
        puz[1] = '{2,0,0,3, 0,4,1,0, 1,0,0,4, 0,3,2,0};
        puz[2] = '{3,0,0,2, 0,2,3,0, 4,0,0,1, 0,1,4,0};
        puz[3] = '{0,1,0,0, 0,0,0,2, 3,0,0,0, 0,0,4,0};

        vecs[0]  = '{B_UP,        0, 3, 0, 1'b0};
        vecs[1]  = '{B_LF,        0, 3, 3, 1'b0};
        vecs[2]  = '{B_DN,        0, 0, 3, 1'b0};
        vecs[3]  = '{B_RT,        0, 0, 0, 1'b0};
        vecs[4]  = '{B_UP | B_DN, 0, 3, 0, 1'b0};
        vecs[5]  = '{B_LF | B_RT, 0, 3, 3, 1'b0};
        vecs[6]  = '{B_DN,        0, 0, 3, 1'b0};
        vecs[7]  = '{B_RT,        0, 0, 0, 1'b0};
        vecs[8]  = '{B_RT,        0, 0, 1, 1'b0};
        vecs[9]  = '{B_CLR | B_RT, 12, 0, 1, 1'b1};
        vecs[10] = '{B_ENT | B_UP, 12, 0, 1, 1'b1};
        vecs[11] = '{B_CLR,       12, 0, 1, 1'b1};

        {btn_new, btn_clear, btn_enter, btn_up, btn_down, btn_left, btn_right} = 7'd0;
        rst        = 1'b1;
        puzzle_sel = 2'd0;

        // Reset state, then the 16-cycle load of puzzle 0.
        step(7'd0, 1'b1, 2'd0);
        chk("rst_grid", grid, 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 15; i++) step(7'd0, 1'b0, 2'd0);
        chk("load_busy_15", 64'(busy), 64'd1);
        step(7'd0, 1'b0, 2'd0);
        chk("load_busy_16", 64'(busy), 64'd0);
        step(7'd0, 1'b0, 2'd0);
        chk("load_fixed", 64'(fixed_mask), 64'h6969);
        chk("load_row0", 64'(grid[15:0]), 64'h4001);
        chk("load_flags", 64'({error_flag, win_flag}), 64'd0);

        // Enter on a given cell is ignored.
        step(B_ENT, 1'b0, 2'd0);
        chk("fixed_enter_grid", grid, P0_HEX);
        chk("fixed_enter_busy", 64'(busy), 64'd0);
        step(7'd0, 1'b0, 2'd0);
        chk("fixed_enter_busy2", 64'(busy), 64'd0);

        // Cursor moves, priorities and clear/enter combined with moves.
        for (int v = 0; v < 12; v++) begin
            step(vecs[v].btn, 1'b0, 2'd0);
            chk($sformatf("vec%0d_row", v), 64'(cursor_row), 64'(vecs[v].row));
            chk($sformatf("vec%0d_col", v), 64'(cursor_col), 64'(vecs[v].col));
            chk($sformatf("vec%0d_busy", v), 64'(busy), 64'(vecs[v].busy));
            for (int i = 0; i < vecs[v].idle; i++) step(7'd0, 1'b0, 2'd0);
        end

        // Digit stepping 0..4 on (0,1), then the wrap to 0 and exact flag latency.
        for (int n = 1; n <= 4; n++) begin
            step(B_ENT, 1'b0, 2'd0);
            chk($sformatf("enter_val%0d", n), 64'(grid[7:4]), 64'(n));
            wait_idle();
        end
        chk("dup4_error", 64'(error_flag), 64'd1);
        step(B_ENT, 1'b0, 2'd0);
        chk("wrap_val", 64'(grid[7:4]), 64'd0);
        for (int i = 0; i < 11; i++) begin
            step(7'd0, 1'b0, 2'd0);
            chk($sformatf("scan_hold_err%0d", i), 64'(error_flag), 64'd1);
            chk($sformatf("scan_busy%0d", i), 64'(busy), 64'd1);
        end
        step(7'd0, 1'b0, 2'd0);
        chk("scan_done_err", 64'(error_flag), 64'd0);
        chk("scan_done_busy", 64'(busy), 64'd0);

        // Solve puzzle 0.
        goto_cell(0, 1); enter_n(2);
        goto_cell(0, 2); enter_n(3);
        goto_cell(1, 0); enter_n(3);
        goto_cell(1, 3); enter_n(2);
        goto_cell(2, 1); enter_n(1);
        goto_cell(2, 2); enter_n(4);
        goto_cell(3, 0); enter_n(4);
        goto_cell(3, 3); enter_n(1);
        chk("win_grid", grid, SOL_HEX);
        chk("win_flag", 64'(win_flag), 64'd1);
        chk("win_err", 64'(error_flag), 64'd0);
        step(B_ENT, 1'b0, 2'd0);
        step(B_UP, 1'b0, 2'd0);
        chk("win_frozen_grid", grid, SOL_HEX);
        chk("win_frozen_cur", 64'({cursor_row, cursor_col}), 64'hF);
        chk("win_frozen_busy", 64'(busy), 64'd0);
        step(B_NEW, 1'b0, 2'd1);
        chk("new_flags", 64'({error_flag, win_flag}), 64'd0);
        chk("new_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 16; i++) step(7'd0, 1'b0, 2'd0);
        chk("p1_grid", grid, P1_HEX);
        chk("p1_busy", 64'(busy), 64'd0);

        // Reset in the middle of a scan.
        step(B_RT, 1'b0, 2'd0);
        step(B_ENT, 1'b0, 2'd0);
        for (int i = 0; i < 5; i++) step(7'd0, 1'b0, 2'd0);
        step(7'd0, 1'b1, 2'd2);
        chk("midrst_grid", grid, 64'd0);
        chk("midrst_fixed", 64'(fixed_mask), 64'd0);
        chk("midrst_cur", 64'({cursor_row, cursor_col}), 64'd0);
        chk("midrst_flags", 64'({error_flag, win_flag}), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 16; i++) step(7'd0, 1'b0, 2'd0);
        chk("p2_grid", grid, P2_HEX);

        // Random button traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] b;
            logic       r;
            b = '0;
            if ($urandom_range(0, 2) == 0) b[5:0] = 6'($urandom);
            b[6] = ($urandom_range(0, 39) == 0);
            r    = ($urandom_range(0, 799) == 0);
            step(b, r, 2'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
